mem_wb_stage: RTL and testbench

Memory-access stage with integrated MEM/WB pipeline register. It sits directly upstream of the write-back stage and executes loads and stores against a word-organised, byte-addressable data memory. It registers every field the write-back stage consumes: control, load data, ALU result, destination register, PC and halt. It also clears the data memory after reset, freezes on halt, and exposes a debug read port to the debug unit.

---
 rtl/mem_wb_stage_if.sv | 48 ++++
 rtl/mem_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle: pipeline fields entering the memory stage and the
// registered fields it presents to write-back.
interface mem_wb_stage_if #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_PC   = 32
);
   logic               i_MEM_mem_read;
   logic               i_MEM_mem_write;
   logic [1:0]         i_MEM_size;
   logic               i_MEM_unsigned;
   logic [NB_DATA-1:0] i_MEM_alu_result;
   logic [NB_DATA-1:0] i_MEM_write_data;
   logic               i_MEM_reg_write;
   logic               i_MEM_mem_to_reg;
   logic               i_MEM_r31_ctrl;
   logic [NB_REG-1:0]  i_MEM_selected_reg;
   logic [NB_PC-1:0]   i_MEM_pc;
   logic               i_MEM_hlt;

   logic               o_WB_reg_write;
   logic               o_WB_mem_to_reg;
   logic               o_WB_r31_ctrl;
   logic               o_WB_hlt;
   logic               o_WB_misaligned;
   logic [NB_DATA-1:0] o_WB_mem_data;
   logic [NB_DATA-1:0] o_WB_alu_result;
   logic [NB_REG-1:0]  o_WB_selected_reg;
   logic [NB_PC-1:0]   o_WB_pc;

   // Upstream side: drives the MEM fields, observes the WB fields.
   modport master (
      output i_MEM_mem_read, i_MEM_mem_write, i_MEM_size, i_MEM_unsigned,
             i_MEM_alu_result, i_MEM_write_data, i_MEM_reg_write, i_MEM_mem_to_reg,
             i_MEM_r31_ctrl, i_MEM_selected_reg, i_MEM_pc, i_MEM_hlt,
      input  o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt, o_WB_misaligned,
             o_WB_mem_data, o_WB_alu_result, o_WB_selected_reg, o_WB_pc
   );

   // Stage side: consumes the MEM fields, produces the WB fields.
   modport slave (
      input  i_MEM_mem_read, i_MEM_mem_write, i_MEM_size, i_MEM_unsigned,
             i_MEM_alu_result, i_MEM_write_data, i_MEM_reg_write, i_MEM_mem_to_reg,
             i_MEM_r31_ctrl, i_MEM_selected_reg, i_MEM_pc, i_MEM_hlt,
      output o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt, o_WB_misaligned,
             o_WB_mem_data, o_WB_alu_result, o_WB_selected_reg, o_WB_pc
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register. Owns a word-organised,
// byte-addressable data memory that is zeroed after every reset, freezes on
// a halt instruction, and exposes a combinational debug read port.
module mem_wb_stage #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_PC   = 32,
   parameter int NB_ADDR = 7
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   mem_wb_stage_if.slave      bus,
   input  logic [NB_ADDR-1:0] i_debug_addr,
   output logic [NB_DATA-1:0] o_debug_data,
   output logic               o_ready
);
   localparam int DEPTH = 1 << NB_ADDR;

   typedef enum logic [1:0] {ST_CLEAR = 2'b00, ST_RUN = 2'b01, ST_HALTED = 2'b10} state_t;

   typedef struct packed {
      logic               reg_write;
      logic               mem_to_reg;
      logic               r31_ctrl;
      logic               hlt;
      logic               misaligned;
      logic [NB_DATA-1:0] mem_data;
      logic [NB_DATA-1:0] alu_result;
      logic [NB_REG-1:0]  selected_reg;
      logic [NB_PC-1:0]   pc;
   } wb_t;

   state_t             state_q, state_d;
   logic [NB_ADDR-1:0] clr_cnt_q, clr_cnt_d;
   logic               ready_q, ready_d;
   wb_t                wb_q, wb_d;
   logic [NB_DATA-1:0] mem_q [DEPTH];

   logic [NB_ADDR-1:0] addr_idx_s;
   logic [1:0]         addr_off_s;
   logic [NB_DATA-1:0] rd_word_s;
   logic [7:0]         lane_b_s;
   logic [15:0]        lane_h_s;
   logic               misaligned_s;
   logic [NB_DATA-1:0] load_data_s;
   logic [NB_DATA-1:0] st_word_s;
   logic               mem_we_s;
   logic [NB_ADDR-1:0] mem_widx_s;
   logic [NB_DATA-1:0] mem_wdata_s;
   logic               unused_addr_s;

   // Bits above the word index are deliberately not decoded.
   assign unused_addr_s = ^bus.i_MEM_alu_result[NB_DATA-1:NB_ADDR+2];

   assign addr_idx_s = bus.i_MEM_alu_result[NB_ADDR+1:2];
   assign addr_off_s = bus.i_MEM_alu_result[1:0];
   // Read happens before this edge's write, so load+store sees the old word.
   assign rd_word_s  = mem_q[addr_idx_s];
   assign lane_b_s   = rd_word_s[{addr_off_s, 3'b000} +: 8];
   assign lane_h_s   = rd_word_s[{addr_off_s[1], 4'b0000} +: 16];

   // Alignment check: halfwords need an even offset, words a zero offset.
   always_comb begin
      misaligned_s = 1'b0;
      case (bus.i_MEM_size)
         2'b00:   misaligned_s = 1'b0;
         2'b01:   misaligned_s = addr_off_s[0];
         default: misaligned_s = (addr_off_s != 2'b00);
      endcase
   end

   // Load path: select lanes and sign/zero extend; zero when no valid load.
   always_comb begin
      load_data_s = '0;
      if (bus.i_MEM_mem_read && !misaligned_s) begin
         case (bus.i_MEM_size)
            2'b00:   load_data_s = {{(NB_DATA-8){~bus.i_MEM_unsigned & lane_b_s[7]}}, lane_b_s};
            2'b01:   load_data_s = {{(NB_DATA-16){~bus.i_MEM_unsigned & lane_h_s[15]}}, lane_h_s};
            default: load_data_s = rd_word_s;
         endcase
      end else begin
         load_data_s = '0;
      end
   end

   // Store path: merge the addressed lanes of the store data into the old word.
   always_comb begin
      st_word_s = rd_word_s;
      case (bus.i_MEM_size)
         2'b00:   st_word_s[{addr_off_s, 3'b000} +: 8]     = bus.i_MEM_write_data[7:0];
         2'b01:   st_word_s[{addr_off_s[1], 4'b0000} +: 16] = bus.i_MEM_write_data[15:0];
         default: st_word_s = bus.i_MEM_write_data;
      endcase
   end

   // Memory write port: clear sweep while clearing, aligned stores while running.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_widx_s  = addr_idx_s;
      mem_wdata_s = st_word_s;
      case (state_q)
         ST_CLEAR: begin
            mem_we_s    = 1'b1;
            mem_widx_s  = clr_cnt_q;
            mem_wdata_s = '0;
         end
         ST_RUN: begin
            if (i_enable && bus.i_MEM_mem_write && !misaligned_s) begin
               mem_we_s = 1'b1;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         default: mem_we_s = 1'b0;
      endcase
   end

   // Data memory array; no writes land while reset is asserted.
   always_ff @(posedge i_clock) begin
      if (i_reset && mem_we_s) begin
         mem_q[mem_widx_s] <= mem_wdata_s;
      end
   end

   // FSM next state, clear counter and MEM/WB register capture.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wb_d      = wb_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + NB_ADDR'(1);
            wb_d      = '0;
            if (clr_cnt_q == {NB_ADDR{1'b1}}) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_RUN: begin
            if (i_enable) begin
               wb_d.reg_write    = bus.i_MEM_reg_write;
               wb_d.mem_to_reg   = bus.i_MEM_mem_to_reg;
               wb_d.r31_ctrl     = bus.i_MEM_r31_ctrl;
               wb_d.hlt          = bus.i_MEM_hlt;
               wb_d.misaligned   = misaligned_s & (bus.i_MEM_mem_read | bus.i_MEM_mem_write);
               wb_d.mem_data     = load_data_s;
               wb_d.alu_result   = bus.i_MEM_alu_result;
               wb_d.selected_reg = bus.i_MEM_selected_reg;
               wb_d.pc           = bus.i_MEM_pc;
               state_d           = bus.i_MEM_hlt ? ST_HALTED : ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            wb_d      = '0;
         end
      endcase
      ready_d = (state_d != ST_CLEAR);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
         wb_q      <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
         wb_q      <= wb_d;
      end
   end

   assign o_ready               = ready_q;
   assign o_debug_data          = mem_q[i_debug_addr];
   assign bus.o_WB_reg_write    = wb_q.reg_write;
   assign bus.o_WB_mem_to_reg   = wb_q.mem_to_reg;
   assign bus.o_WB_r31_ctrl     = wb_q.r31_ctrl;
   assign bus.o_WB_hlt          = wb_q.hlt;
   assign bus.o_WB_misaligned   = wb_q.misaligned;
   assign bus.o_WB_mem_data     = wb_q.mem_data;
   assign bus.o_WB_alu_result   = wb_q.alu_result;
   assign bus.o_WB_selected_reg = wb_q.selected_reg;
   assign bus.o_WB_pc           = wb_q.pc;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random
// traffic, all compared against a byte-level reference memory model.
module tb_mem_wb_stage;
   localparam int WBW = 5 + 32 + 32 + 5 + 32;

   logic        clk;
   logic        i_reset;
   logic        i_enable;
   logic [6:0]  i_debug_addr;
   logic [31:0] o_debug_data;
   logic        o_ready;

   mem_wb_stage_if #(.NB_DATA(32), .NB_REG(5), .NB_PC(32)) bus ();

   mem_wb_stage #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .NB_ADDR(7)) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .bus          (bus),
      .i_debug_addr (i_debug_addr),
      .o_debug_data (o_debug_data),
      .o_ready      (o_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0]    m_mem [128];
   bit             m_halted;
   logic [WBW-1:0] e_pack;

   function automatic logic [WBW-1:0] act_pack();
      return {bus.o_WB_reg_write, bus.o_WB_mem_to_reg, bus.o_WB_r31_ctrl, bus.o_WB_hlt,
              bus.o_WB_misaligned, bus.o_WB_mem_data, bus.o_WB_alu_result,
              bus.o_WB_selected_reg, bus.o_WB_pc};
   endfunction

   // One enabled instruction as the architecture defines it, byte by byte.
   function automatic void model_step();
      int          off, idx, nb;
      bit          mis;
      logic [31:0] word, ld, wd, addr;
      if (m_halted || !i_enable) return;
      addr = bus.i_MEM_alu_result;
      wd   = bus.i_MEM_write_data;
      off  = int'(addr % 4);
      idx  = int'((addr / 4) % 128);
      nb   = (bus.i_MEM_size == 2'd0) ? 1 : (bus.i_MEM_size == 2'd1) ? 2 : 4;
      mis  = (off % nb) != 0;
      word = m_mem[idx];
      ld   = 32'd0;
      if (bus.i_MEM_mem_read && !mis) begin
         for (int b = 0; b < nb; b++) ld[8*b +: 8] = word[8*(off+b) +: 8];
         if (nb < 4 && !bus.i_MEM_unsigned && ld[8*nb-1])
            for (int b = nb; b < 4; b++) ld[8*b +: 8] = 8'hFF;
      end
      if (bus.i_MEM_mem_write && !mis) begin
         for (int b = 0; b < nb; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
         m_mem[idx] = word;
      end
      e_pack = {bus.i_MEM_reg_write, bus.i_MEM_mem_to_reg, bus.i_MEM_r31_ctrl, bus.i_MEM_hlt,
                mis & (bus.i_MEM_mem_read | bus.i_MEM_mem_write), ld, addr,
                bus.i_MEM_selected_reg, bus.i_MEM_pc};
      if (bus.i_MEM_hlt) m_halted = 1'b1;
   endfunction

   task automatic randomize_pipe();
      bus.i_MEM_mem_read     = 1'($urandom);
      bus.i_MEM_mem_write    = 1'($urandom);
      bus.i_MEM_size         = 2'($urandom);
      bus.i_MEM_unsigned     = 1'($urandom);
      bus.i_MEM_alu_result   = $urandom;
      bus.i_MEM_write_data   = $urandom;
      bus.i_MEM_reg_write    = 1'($urandom);
      bus.i_MEM_mem_to_reg   = 1'($urandom);
      bus.i_MEM_r31_ctrl     = 1'($urandom);
      bus.i_MEM_selected_reg = 5'($urandom);
      bus.i_MEM_pc           = $urandom;
      bus.i_MEM_hlt          = 1'($urandom);
   endtask

   // Present one instruction (random passthrough fields), update model, clock.
   task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hlt,
                     input bit en);
      randomize_pipe();
      bus.i_MEM_mem_read   = rd;
      bus.i_MEM_mem_write  = wr;
      bus.i_MEM_size       = sz;
      bus.i_MEM_unsigned   = uns;
      bus.i_MEM_alu_result = addr;
      bus.i_MEM_write_data = wdata;
      bus.i_MEM_hlt        = hlt;
      i_enable             = en;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int cyc;
      bit wb_nonzero;
      i_reset = 1'b0;
      randomize_pipe();
      i_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", o_ready); end
      checks++;
      if (act_pack() !== '0) begin errors++; $display("FAIL reset_wb got %h exp 0", act_pack()); end
      i_reset    = 1'b1;
      cyc        = 0;
      wb_nonzero = 1'b0;
      while (cyc < 200) begin
         randomize_pipe();
         i_enable = 1'($urandom);
         @(posedge clk);
         #1;
         cyc++;
         if (act_pack() !== '0) wb_nonzero = 1'b1;
         if (o_ready === 1'b1) break;
      end
      i_enable = 1'b0;
      checks++;
      if (cyc != 128 || o_ready !== 1'b1) begin
         errors++; $display("FAIL clear_len got %0d ready %b exp 128 ready 1", cyc, o_ready);
      end
      checks++;
      if (wb_nonzero) begin errors++; $display("FAIL clear_wb_zero got nonzero exp 0"); end
      for (int i = 0; i < 128; i++) m_mem[i] = 32'd0;
      m_halted = 1'b0;
      e_pack   = '0;
      for (int i = 0; i < 128; i++) begin
         i_debug_addr = 7'(i);
         #1;
         checks++;
         if (o_debug_data !== 32'd0) begin
            errors++; $display("FAIL clear_mem[%0d] got %h exp 0", i, o_debug_data);
         end
      end
   endtask

   task automatic test_byte_loads();
      logic [31:0] exp_b [4];
      exp_b[0] = 32'hFFFFFFEF; exp_b[1] = 32'hFFFFFFBE;
      exp_b[2] = 32'hFFFFFFAD; exp_b[3] = 32'hFFFFFFDE;
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
      checks++;
      if (act_pack() !== e_pack) begin errors++; $display("FAIL st_word got %h exp %h", act_pack(), e_pack); end
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 1'b0, 2'b00, 1'b0, 32'h10 + 32'(i), 32'h0, 1'b0, 1'b1);
         checks++;
         if (bus.o_WB_mem_data !== exp_b[i] || act_pack() !== e_pack) begin
            errors++; $display("FAIL ld_byte_s@%0d got %h exp %h", i, bus.o_WB_mem_data, exp_b[i]);
         end
      end
      op(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 1'b1);
      checks++;
      if (bus.o_WB_mem_data !== 32'h000000DE) begin
         errors++; $display("FAIL ld_byte_u got %h exp 000000de", bus.o_WB_mem_data);
      end
   endtask

   task automatic test_half();
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
      op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD1234, 1'b0, 1'b1);
      i_debug_addr = 7'd8;
      #1;
      checks++;
      if (o_debug_data !== 32'h12340000) begin
         errors++; $display("FAIL st_half got %h exp 12340000", o_debug_data);
      end
      op(1'b0, 1'b1, 2'b01, 1'b0, 32'h24, 32'h00008001, 1'b0, 1'b1);
      op(1'b1, 1'b0, 2'b01, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
      checks++;
      if (bus.o_WB_mem_data !== 32'hFFFF8001 || act_pack() !== e_pack) begin
         errors++; $display("FAIL ld_half_s got %h exp ffff8001", bus.o_WB_mem_data);
      end
   endtask

   task automatic test_misaligned();
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h11223344, 1'b0, 1'b1);
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h05, 32'hCAFEF00D, 1'b0, 1'b1);
      i_debug_addr = 7'd1;
      #1;
      checks++;
      if (o_debug_data !== 32'h11223344) begin
         errors++; $display("FAIL mis_store_mem got %h exp 11223344", o_debug_data);
      end
      checks++;
      if (bus.o_WB_misaligned !== 1'b1 || act_pack() !== e_pack) begin
         errors++; $display("FAIL mis_store_flag got %b exp 1", bus.o_WB_misaligned);
      end
      op(1'b1, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b0, 1'b1);
      checks++;
      if (bus.o_WB_mem_data !== 32'd0 || bus.o_WB_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_half_load got %h/%b exp 0/1", bus.o_WB_mem_data, bus.o_WB_misaligned);
      end
   endtask

   task automatic test_enable();
      logic [WBW-1:0] held;
      held = act_pack();
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h5A5A1234, 1'b0, 1'b0);
      i_debug_addr = 7'd12;
      #1;
      checks++;
      if (act_pack() !== held || o_debug_data !== m_mem[12]) begin
         errors++; $display("FAIL enable_hold got %h exp %h", o_debug_data, m_mem[12]);
      end
      i_enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      checks++;
      if (o_debug_data !== 32'h5A5A1234 || act_pack() !== e_pack) begin
         errors++; $display("FAIL enable_store got %h exp 5a5a1234", o_debug_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      d = $urandom;
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, d, 1'b0, 1'b1);
      op(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
      checks++;
      if (bus.o_WB_mem_data !== d) begin
         errors++; $display("FAIL b2b_load got %h exp %h", bus.o_WB_mem_data, d);
      end
      // load and store together: load returns the pre-write word
      op(1'b1, 1'b1, 2'b11, 1'b0, 32'h40, ~d, 1'b0, 1'b1);
      checks++;
      if (bus.o_WB_mem_data !== d || act_pack() !== e_pack) begin
         errors++; $display("FAIL ld_st_same got %h exp %h", bus.o_WB_mem_data, d);
      end
   endtask

   task automatic test_random();
      int k;
      for (int n = 0; n < 400; n++) begin
         op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            {$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 63)), $urandom,
            1'b0, ($urandom_range(0, 3) != 0));
         checks++;
         if (act_pack() !== e_pack) begin
            errors++; $display("FAIL rand_wb[%0d] got %h exp %h", n, act_pack(), e_pack);
         end
         k = $urandom_range(0, 15);
         i_debug_addr = 7'(k);
         #1;
         checks++;
         if (o_debug_data !== m_mem[k]) begin
            errors++; $display("FAIL rand_mem[%0d] got %h exp %h", k, o_debug_data, m_mem[k]);
         end
      end
   endtask

   task automatic test_halt();
      op(1'b0, 1'b1, 2'b11, 1'b0, 32'h08, 32'h0BADC0DE, 1'b1, 1'b1);
      checks++;
      if (bus.o_WB_hlt !== 1'b1 || act_pack() !== e_pack) begin
         errors++; $display("FAIL halt_capture got %b exp 1", bus.o_WB_hlt);
      end
      for (int n = 0; n < 12; n++) begin
         op(1'($urandom), 1'b1, 2'b11, 1'b0, 32'($urandom_range(0, 511)), $urandom,
            1'($urandom), 1'($urandom));
         checks++;
         if (act_pack() !== e_pack) begin
            errors++; $display("FAIL halt_hold[%0d] got %h exp %h", n, act_pack(), e_pack);
         end
      end
      for (int i = 0; i < 128; i++) begin
         i_debug_addr = 7'(i);
         #1;
         checks++;
         if (o_debug_data !== m_mem[i]) begin
            errors++; $display("FAIL halt_mem[%0d] got %h exp %h", i, o_debug_data, m_mem[i]);
         end
      end
   endtask

   initial begin
      i_reset      = 1'b0;
      i_enable     = 1'b0;
      i_debug_addr = 7'd0;
      randomize_pipe();
      #1;
      test_reset();
      test_byte_loads();
      test_half();
      test_misaligned();
      test_enable();
      test_back_to_back();
      test_random();
      test_halt();
      test_reset();
      test_byte_loads();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
